// File: rtl/encode_pri_rr_if.sv
// ---------------------------------------------------------------------------
// encode_pri_rr_if
//   Request/result bundle between a request source, the encode_pri_rr
//   selector and the downstream consumer.
//
//   Signals
//     en         source -> block  encode enable, sampled with x on a transfer
//     in_valid   source -> block  x/en are valid this cycle
//     in_ready   block  -> source block can accept x this cycle
//     x          source -> block  request vector, N bits
//     out_valid  block  -> sink   y/none/multi hold a result
//     out_ready  sink   -> block  consumer accepts the result this cycle
//     y          block  -> sink   encoded index of the granted request
//     none       block  -> sink   result had no request (x==0 or en==0)
//     multi      block  -> sink   more than one request bit was set
//
//   Modports
//     slave   : the encoder's view
//     master  : the environment's view (source plus consumer)
// ---------------------------------------------------------------------------
interface encode_pri_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         none;
  logic         multi;

  modport slave (
    input  en,
    input  in_valid,
    input  x,
    input  out_ready,
    output in_ready,
    output out_valid,
    output y,
    output none,
    output multi
  );

  modport master (
    output en,
    output in_valid,
    output x,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  y,
    input  none,
    input  multi
  );
endinterface

// File: rtl/encode_pri_rr.sv
// ---------------------------------------------------------------------------
// encode_pri_rr
//   N-to-log2(N) priority encoder with a registered result and valid/ready
//   handshake on both sides. Selects one request out of x according to MODE:
//     0 : fixed priority, highest index wins
//     1 : fixed priority, lowest index wins
//     2 : round-robin, search starts just after the last granted index
//
//   Ports
//     clk     clock, all state changes on the rising edge
//     rst     asynchronous active-high reset
//     io_bus  encode_pri_rr_if slave modport (en, in_valid/in_ready, x,
//             out_valid/out_ready, y, none, multi)
//
//   Parameters
//     N     number of request lines, N >= 2, need not be a power of two
//     MODE  selection policy as listed above
// ---------------------------------------------------------------------------
module encode_pri_rr #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic           clk,
  input  logic           rst,
  encode_pri_rr_if.slave io_bus
);
  localparam int         W     = $clog2(N);
  // N held in W+1 bits: enough for the ptr+offset sum, which is < 2N.
  localparam logic [W:0] N_EXT = (W+1)'(N);

  // Registered result and round-robin pointer
  logic         r_out_valid;
  logic [W-1:0] r_y;
  logic         r_none;
  logic         r_multi;
  logic [W-1:0] r_ptr;

  // Combinational selection path
  logic         w_in_ready;
  logic         w_in_xfer;
  logic [N-1:0] w_req;
  logic         w_any;
  logic         w_multi;
  logic [W-1:0] w_hi_idx;
  logic [W-1:0] w_lo_idx;
  logic [W-1:0] w_rr_idx;
  logic [W-1:0] w_sel_idx;
  logic [W-1:0] w_rot_idx [N];
  logic [N-1:0] w_rot_req;

  // Accept whenever the output slot is empty or is being drained this cycle.
  assign w_in_ready = !r_out_valid || io_bus.out_ready;
  assign w_in_xfer  = io_bus.in_valid && w_in_ready;

  // en=0 behaves exactly like an all-zero request vector.
  assign w_req   = io_bus.en ? io_bus.x : '0;
  assign w_any   = |w_req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(w_req & (w_req - N'(1)));

  // Round-robin view of the requests: slot gi holds request (ptr+1+gi) mod N,
  // so slot 0 is the first candidate and slot N-1 is ptr itself. The wrap is
  // done against N, never against 2^W, so non-power-of-two N never yields an
  // index >= N.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      logic [W:0] w_sum;
      assign w_sum          = {1'b0, r_ptr} + (W+1)'(gi + 1);
      assign w_rot_idx[gi]  = (w_sum >= N_EXT) ? W'(w_sum - N_EXT) : W'(w_sum);
      assign w_rot_req[gi]  = w_req[w_rot_idx[gi]];
    end
  endgenerate

  // Highest set index: later iterations override earlier ones.
  always_comb begin
    w_hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_req[i]) w_hi_idx = W'(i);
    end
  end

  // Lowest set index.
  always_comb begin
    w_lo_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_req[i]) w_lo_idx = W'(i);
    end
  end

  // First requesting slot in round-robin order.
  always_comb begin
    w_rr_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot_req[i]) w_rr_idx = w_rot_idx[i];
    end
  end

  always_comb begin
    w_sel_idx = '0;
    case (MODE)
      0:       w_sel_idx = w_hi_idx;
      1:       w_sel_idx = w_lo_idx;
      default: w_sel_idx = w_rr_idx;
    endcase
  end

  // Result register. A new input overwrites the slot in the same edge that
  // the old result is drained, so back-to-back transfers have no bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_none      <= 1'b0;
      r_multi     <= 1'b0;
      r_ptr       <= W'(N - 1);
    end else begin
      if (w_in_xfer) begin
        r_out_valid <= 1'b1;
        r_y         <= w_any ? w_sel_idx : '0;
        r_none      <= !w_any;
        r_multi     <= w_multi;
        // Pointer only moves on an actual grant; empty results keep it.
        if (MODE == 2 && w_any) begin
          r_ptr <= w_sel_idx;
        end
      end else if (io_bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.y         = r_y;
  assign io_bus.none      = r_none;
  assign io_bus.multi     = r_multi;
endmodule

// File: tb/tb_encode_pri_rr.sv
// ---------------------------------------------------------------------------
// tb_encode_pri_rr
//   Five encoder instances share one stimulus stream:
//     0: N=4 MODE0   1: N=8 MODE0   2: N=8 MODE1   3: N=8 MODE2   4: N=5 MODE2
//   Narrow instances see the low bits of x.
// ---------------------------------------------------------------------------
module tb_encode_pri_rr;
  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] x;

  int checks = 0;
  int errors = 0;

  int    cfg_n    [5] = '{4, 8, 8, 8, 5};
  int    cfg_mode [5] = '{0, 0, 1, 2, 2};
  string nm       [5] = '{"n4m0", "n8m0", "n8m1", "n8m2", "n5m2"};

  always #5 clk = ~clk;

  encode_pri_rr_if #(.N(4)) bus0 ();
  encode_pri_rr_if #(.N(8)) bus1 ();
  encode_pri_rr_if #(.N(8)) bus2 ();
  encode_pri_rr_if #(.N(8)) bus3 ();
  encode_pri_rr_if #(.N(5)) bus4 ();

  assign bus0.en = en; assign bus0.in_valid = in_valid; assign bus0.out_ready = out_ready; assign bus0.x = x[3:0];
  assign bus1.en = en; assign bus1.in_valid = in_valid; assign bus1.out_ready = out_ready; assign bus1.x = x;
  assign bus2.en = en; assign bus2.in_valid = in_valid; assign bus2.out_ready = out_ready; assign bus2.x = x;
  assign bus3.en = en; assign bus3.in_valid = in_valid; assign bus3.out_ready = out_ready; assign bus3.x = x;
  assign bus4.en = en; assign bus4.in_valid = in_valid; assign bus4.out_ready = out_ready; assign bus4.x = x[4:0];

  encode_pri_rr #(.N(4), .MODE(0)) u_n4m0 (.clk(clk), .rst(rst), .io_bus(bus0));
  encode_pri_rr #(.N(8), .MODE(0)) u_n8m0 (.clk(clk), .rst(rst), .io_bus(bus1));
  encode_pri_rr #(.N(8), .MODE(1)) u_n8m1 (.clk(clk), .rst(rst), .io_bus(bus2));
  encode_pri_rr #(.N(8), .MODE(2)) u_n8m2 (.clk(clk), .rst(rst), .io_bus(bus3));
  encode_pri_rr #(.N(5), .MODE(2)) u_n5m2 (.clk(clk), .rst(rst), .io_bus(bus4));

  logic       ov [5];
  logic       ir [5];
  logic       nn [5];
  logic       mu [5];
  logic [2:0] yy [5];

  assign ov[0] = bus0.out_valid; assign ir[0] = bus0.in_ready; assign nn[0] = bus0.none; assign mu[0] = bus0.multi; assign yy[0] = {1'b0, bus0.y};
  assign ov[1] = bus1.out_valid; assign ir[1] = bus1.in_ready; assign nn[1] = bus1.none; assign mu[1] = bus1.multi; assign yy[1] = bus1.y;
  assign ov[2] = bus2.out_valid; assign ir[2] = bus2.in_ready; assign nn[2] = bus2.none; assign mu[2] = bus2.multi; assign yy[2] = bus2.y;
  assign ov[3] = bus3.out_valid; assign ir[3] = bus3.in_ready; assign nn[3] = bus3.none; assign mu[3] = bus3.multi; assign yy[3] = bus3.y;
  assign ov[4] = bus4.out_valid; assign ir[4] = bus4.in_ready; assign nn[4] = bus4.none; assign mu[4] = bus4.multi; assign yy[4] = bus4.y;

  // Reference: pick the granted index straight from the selection rules.
  function automatic int ref_pick(int n, int mode, int ptr, logic [7:0] xm);
    int r;
    r = -1;
    if (mode == 0) begin
      for (int k = 0; k < n; k++) if (xm[k]) r = k;
    end else if (mode == 1) begin
      for (int k = n - 1; k >= 0; k--) if (xm[k]) r = k;
    end else begin
      // scan ptr+1 .. ptr+n (mod n); iterate backwards so the first hit wins
      for (int k = n; k >= 1; k--) if (xm[(ptr + k) % n]) r = (ptr + k) % n;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0;
    #2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || yy[i] !== 3'd0 || nn[i] !== 1'b0 || mu[i] !== 1'b0 || ir[i] !== 1'b1) begin
        errors++;
        $display("FAIL reset_%s: got v=%0b y=%0d n=%0b m=%0b rdy=%0b expected v=0 y=0 n=0 m=0 rdy=1",
                 nm[i], ov[i], yy[i], nn[i], mu[i], ir[i]);
      end
    end
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    int exp_y [5];
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; x = 8'h04;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || yy[i] !== 3'd2 || nn[i] !== 1'b0 || mu[i] !== 1'b0) begin
        errors++;
        $display("FAIL onehot_%s: got v=%0b y=%0d n=%0b m=%0b expected v=1 y=2 n=0 m=0",
                 nm[i], ov[i], yy[i], nn[i], mu[i]);
      end
    end
    x = 8'b0001_0110;
    exp_y = '{2, 4, 1, 4, 4};
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || yy[i] !== 3'(exp_y[i]) || nn[i] !== 1'b0 || mu[i] !== 1'b1) begin
        errors++;
        $display("FAIL multi_%s: got v=%0b y=%0d n=%0b m=%0b expected v=1 y=%0d n=0 m=1",
                 nm[i], ov[i], yy[i], nn[i], mu[i], exp_y[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b0) begin
        errors++;
        $display("FAIL drain_%s: got v=%0b expected v=0", nm[i], ov[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    int exp8 [4] = '{0, 2, 7, 0};
    int exp5 [4] = '{0, 2, 0, 2};
    int expw [4] = '{0, 4, 0, 4};
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; x = 8'h85;
    for (int t = 0; t < 4; t++) begin
      tick();
      checks++;
      if (ov[3] !== 1'b1 || yy[3] !== 3'(exp8[t])) begin
        errors++;
        $display("FAIL rr8_step%0d: got v=%0b y=%0d expected v=1 y=%0d", t, ov[3], yy[3], exp8[t]);
      end
      checks++;
      if (ov[4] !== 1'b1 || yy[4] !== 3'(exp5[t])) begin
        errors++;
        $display("FAIL rr5a_step%0d: got v=%0b y=%0d expected v=1 y=%0d", t, ov[4], yy[4], exp5[t]);
      end
    end
    do_reset();
    x = 8'h11;
    for (int t = 0; t < 4; t++) begin
      tick();
      for (int i = 3; i < 5; i++) begin
        checks++;
        if (ov[i] !== 1'b1 || yy[i] !== 3'(expw[t]) || mu[i] !== 1'b1) begin
          errors++;
          $display("FAIL rrwrap_%s_step%0d: got v=%0b y=%0d m=%0b expected v=1 y=%0d m=1",
                   nm[i], t, ov[i], yy[i], mu[i], expw[t]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b0; x = 8'h10;
    tick();
    x = 8'h01;
    for (int t = 0; t < 3; t++) begin
      for (int i = 1; i < 4; i++) begin
        checks++;
        if (ov[i] !== 1'b1 || yy[i] !== 3'd4 || ir[i] !== 1'b0) begin
          errors++;
          $display("FAIL hold_%s_cyc%0d: got v=%0b y=%0d rdy=%0b expected v=1 y=4 rdy=0",
                   nm[i], t, ov[i], yy[i], ir[i]);
        end
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (ir[i] !== 1'b1) begin
        errors++;
        $display("FAIL release_rdy_%s: got rdy=%0b expected rdy=1", nm[i], ir[i]);
      end
    end
    tick();
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || yy[i] !== 3'd0 || mu[i] !== 1'b0) begin
        errors++;
        $display("FAIL release_%s: got v=%0b y=%0d m=%0b expected v=1 y=0 m=0", nm[i], ov[i], yy[i], mu[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_none();
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b1; x = 8'h84;
    tick();
    checks++;
    if (yy[3] !== 3'd2) begin
      errors++;
      $display("FAIL none_pre_n8m2: got y=%0d expected y=2", yy[3]);
    end
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin en = 1'b0; x = 8'hFF; end
      else        begin en = 1'b1; x = 8'h00; end
      tick();
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ov[i] !== 1'b1 || yy[i] !== 3'd0 || nn[i] !== 1'b1 || mu[i] !== 1'b0) begin
          errors++;
          $display("FAIL none%0d_%s: got v=%0b y=%0d n=%0b m=%0b expected v=1 y=0 n=1 m=0",
                   s, nm[i], ov[i], yy[i], nn[i], mu[i]);
        end
      end
    end
    en = 1'b1; x = 8'h85;
    tick();
    checks++;
    if (yy[3] !== 3'd7 || nn[3] !== 1'b0) begin
      errors++;
      $display("FAIL none_ptr_n8m2: got y=%0d n=%0b expected y=7 n=0", yy[3], nn[3]);
    end
    checks++;
    if (yy[4] !== 3'd0 || nn[4] !== 1'b0) begin
      errors++;
      $display("FAIL none_ptr_n5m2: got y=%0d n=%0b expected y=0 n=0", yy[4], nn[4]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1; in_valid = 1'b1; out_ready = 1'b0; x = 8'hC0;
    tick();
    checks++;
    if (ov[1] !== 1'b1 || yy[1] !== 3'd7 || mu[1] !== 1'b1) begin
      errors++;
      $display("FAIL areset_load: got v=%0b y=%0d m=%0b expected v=1 y=7 m=1", ov[1], yy[1], mu[1]);
    end
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || yy[i] !== 3'd0 || nn[i] !== 1'b0 || mu[i] !== 1'b0) begin
        errors++;
        $display("FAIL areset_%s: got v=%0b y=%0d n=%0b m=%0b expected v=0 y=0 n=0 m=0",
                 nm[i], ov[i], yy[i], nn[i], mu[i]);
      end
    end
    #2;
    rst = 1'b0;
    x = 8'hFF; en = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    for (int i = 3; i < 5; i++) begin
      checks++;
      if (ov[i] !== 1'b1 || yy[i] !== 3'd0 || mu[i] !== 1'b1) begin
        errors++;
        $display("FAIL areset_first_%s: got v=%0b y=%0d m=%0b expected v=1 y=0 m=1", nm[i], ov[i], yy[i], mu[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit         m_ov    [5];
    logic [2:0] m_y     [5];
    bit         m_none  [5];
    bit         m_multi [5];
    int         m_ptr   [5];
    logic [8:0] m9;
    logic [7:0] xm;
    logic       exp_ir;
    int         r;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      m_ov[i] = 0; m_y[i] = '0; m_none[i] = 0; m_multi[i] = 0; m_ptr[i] = cfg_n[i] - 1;
    end
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 4) > 1);
      en        = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      if (r == 0)     x = 8'h00;
      else if (r < 4) x = 8'(1 << $urandom_range(0, 7));
      else            x = 8'($urandom);
      #1;
      for (int i = 0; i < 5; i++) begin
        exp_ir = !m_ov[i] || out_ready;
        checks++;
        if (ir[i] !== exp_ir) begin
          errors++;
          $display("FAIL rand_rdy_%s cyc%0d: got rdy=%0b expected rdy=%0b", nm[i], c, ir[i], exp_ir);
        end
        if (in_valid && exp_ir) begin
          m9 = (9'd1 << cfg_n[i]) - 9'd1;
          xm = x & m9[7:0];
          m_ov[i] = 1;
          if (!en || xm == 8'h00) begin
            m_y[i] = '0; m_none[i] = 1; m_multi[i] = 0;
          end else begin
            m_y[i]     = 3'(ref_pick(cfg_n[i], cfg_mode[i], m_ptr[i], xm));
            m_none[i]  = 0;
            m_multi[i] = ($countones(xm) > 1);
            if (cfg_mode[i] == 2) m_ptr[i] = int'(m_y[i]);
          end
        end else if (out_ready) begin
          m_ov[i] = 0;
        end
      end
      tick();
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (ov[i] !== m_ov[i] ||
            (m_ov[i] && (yy[i] !== m_y[i] || nn[i] !== m_none[i] || mu[i] !== m_multi[i]))) begin
          errors++;
          $display("FAIL rand_out_%s cyc%0d: got v=%0b y=%0d n=%0b m=%0b expected v=%0b y=%0d n=%0b m=%0b",
                   nm[i], c, ov[i], yy[i], nn[i], mu[i], m_ov[i], m_y[i], m_none[i], m_multi[i]);
        end
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fixed();
    test_round_robin();
    test_back_pressure();
    test_none();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
